// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU type definitions
// Purpose: ALU and multiply/divide operation encodings, MDU state
// encoding and the iteration count of the multi-cycle MDU.
package cpu_types_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_LUI
  } aluop_t;

  typedef enum logic [1:0] {
    MDU_MULT,
    MDU_MULTU,
    MDU_DIV,
    MDU_DIVU
  } mduop_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } mdu_state_t;

  // One shift-add or subtract-shift step per bit of operand.
  localparam int MDU_STEPS = 32;

endpackage

// File: rtl/mdu_signfix.sv
// rtl/mdu_signfix.sv - sign correction of raw MDU magnitude results
// Purpose: turn the unsigned magnitude result left in the iteration
// register into the final HI/LO words.
// Ports:
//   is_div  - result came from a divide (else multiply)
//   neg_q   - product / quotient must be negated
//   neg_r   - remainder must be negated (takes dividend sign)
//   dbz     - divide by zero; quotient forced to all ones
//   acc     - raw result: {product} or {remainder, quotient}
//   hi, lo  - corrected HI and LO words
module mdu_signfix (
  input  logic        is_div,
  input  logic        neg_q,
  input  logic        neg_r,
  input  logic        dbz,
  input  logic [63:0] acc,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  always_comb begin
    hi = acc[63:32];
    lo = acc[31:0];
    if (is_div) begin
      // With a zero divisor the remainder magnitude equals |dividend|;
      // restoring the dividend sign reproduces the dividend exactly.
      lo = dbz ? 32'hFFFF_FFFF : (neg_q ? 32'd0 - acc[31:0] : acc[31:0]);
      hi = neg_r ? 32'd0 - acc[63:32] : acc[63:32];
    end else if (neg_q) begin
      {hi, lo} = 64'd0 - acc;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 32-bit multiply / divide unit
// Purpose: fixed-latency MULT/MULTU/DIV/DIVU; one step per cycle over
// 32 RUN cycles, sign correction in FIX, HI/LO written at the end.
// Ports:
//   CLK, RST      - clock, synchronous active-high reset
//   start, mduop  - request and operation, sampled when idle
//   Port_A/Port_B - multiplicand/dividend, multiplier/divisor
//   flush         - abort the operation in flight
//   busy, done    - in flight / one-cycle completion pulse
//   hi, lo        - HI and LO result registers
//   div_by_zero   - divide with zero divisor, valid with done
module mul_div_unit
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  mduop_t      mduop,
  input  logic [31:0] Port_A,
  input  logic [31:0] Port_B,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  localparam logic [4:0] STEP_LAST = 5'(MDU_STEPS - 1);

  mdu_state_t  state;
  logic [4:0]  cnt;
  logic        is_div, neg_q, neg_r, dbz_q;
  logic [31:0] mcand;   // multiplicand or divisor magnitude
  logic [63:0] acc;     // {upper, multiplier} or {remainder, quotient}

  logic        op_is_div, signed_op, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] add_sum, shifted;
  logic [31:0] diff;
  logic        ge;
  logic [63:0] step_next;
  logic [31:0] fix_hi, fix_lo;

  always_comb begin
    op_is_div = (mduop == MDU_DIV) || (mduop == MDU_DIVU);
    signed_op = (mduop == MDU_MULT) || (mduop == MDU_DIV);
    a_neg     = signed_op && Port_A[31];
    b_neg     = signed_op && Port_B[31];
    a_mag     = a_neg ? 32'd0 - Port_A : Port_A;
    b_mag     = b_neg ? 32'd0 - Port_B : Port_B;
  end

  always_comb begin
    add_sum = {1'b0, acc[63:32]} + {1'b0, mcand};
    shifted = {acc[63:32], acc[31]};
    ge      = shifted >= {1'b0, mcand};
    // Remainder stays below the divisor, so when ge holds the true
    // difference fits in 32 bits.
    diff    = shifted[31:0] - mcand;
    if (is_div) begin
      step_next = ge ? {diff, acc[30:0], 1'b1} : {shifted[31:0], acc[30:0], 1'b0};
    end else begin
      step_next = acc[0] ? {add_sum, acc[31:1]} : {1'b0, acc[63:1]};
    end
  end

  mdu_signfix u_signfix (
    .is_div (is_div),
    .neg_q  (neg_q),
    .neg_r  (neg_r),
    .dbz    (dbz_q),
    .acc    (acc),
    .hi     (fix_hi),
    .lo     (fix_lo)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      cnt         <= 5'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      div_by_zero <= 1'b0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz_q       <= 1'b0;
      mcand       <= 32'd0;
      acc         <= 64'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !flush) begin
            state  <= ST_RUN;
            busy   <= 1'b1;
            cnt    <= 5'd0;
            is_div <= op_is_div;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dbz_q  <= op_is_div && (Port_B == 32'd0);
            mcand  <= op_is_div ? b_mag : a_mag;
            acc    <= {32'd0, op_is_div ? a_mag : b_mag};
          end
        end
        ST_RUN: begin
          if (flush) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= step_next;
            cnt <= cnt + 5'd1;
            if (cnt == STEP_LAST) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            hi          <= fix_hi;
            lo          <= fix_lo;
            div_by_zero <= dbz_q;
            done        <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
module tb_mul_div_unit;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  mduop_t      mduop = MDU_MULT;
  logic [31:0] Port_A = 32'd0;
  logic [31:0] Port_B = 32'd0;
  logic        flush = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  mul_div_unit dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .mduop       (mduop),
    .Port_A      (Port_A),
    .Port_B      (Port_B),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference results from plain integer arithmetic.
  task automatic model_calc(input mduop_t op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] rh, output logic [31:0] rl, output logic rz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    rz = 1'b0;
    rh = 32'd0;
    rl = 32'd0;
    case (op)
      MDU_MULT:  begin p = 64'(sa * sb); rh = p[63:32]; rl = p[31:0]; end
      MDU_MULTU: begin p = {32'd0, a} * {32'd0, b}; rh = p[63:32]; rl = p[31:0]; end
      MDU_DIV, MDU_DIVU: begin
        if (b == 32'd0) begin
          rz = 1'b1; rl = 32'hFFFF_FFFF; rh = a;
        end else if (op == MDU_DIV) begin
          q = sa / sb; r = sa % sb;
          p = 64'(q); rl = p[31:0];
          p = 64'(r); rh = p[31:0];
        end else begin
          rl = a / b; rh = a % b;
        end
      end
      default: ;
    endcase
  endtask

  // Cycle model: an accepted request completes 33 edges later unless
  // flushed or reset; results are only published on completion.
  bit          m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0, p_dbz;
  int          m_left = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi, p_lo;

  always @(posedge CLK) begin
    if (RST) begin
      m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
      m_hi = 32'd0; m_lo = 32'd0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (flush) begin
          m_busy = 1'b0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 1'b0; m_done = 1'b1;
            m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz;
          end
        end
      end else if (start && !flush) begin
        model_calc(mduop, Port_A, Port_B, p_hi, p_lo, p_dbz);
        m_busy = 1'b1;
        m_left = 33;
      end
    end
  end

  always @(negedge CLK) begin
    if (check_en) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
      if (m_done) chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
    end
  end

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input mduop_t op, input logic [31:0] a, input logic [31:0] b);
    @(posedge CLK); #1;
    start = 1'b1; mduop = op; Port_A = a; Port_B = b;
    @(posedge CLK); #1;
    start = 1'b0;
    mduop = mduop_t'($urandom_range(0, 3));
    Port_A = $urandom; Port_B = $urandom;
  endtask

  // Returns at the falling edge where done is seen; cyc counts edges
  // after the accepting edge.
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (done) return;
      cyc++;
    end
    chk("done_timeout", 64'(done), 64'd1);
  endtask

  int cyc, ndone;

  initial begin
    @(posedge CLK); #1;
    check_en = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);

    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc);
    chk("multu_latency", 64'(cyc), 64'd33);
    chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    issue(MDU_MULT, 32'hFFFF_FFFB, 32'd10);
    wait_done(cyc);
    chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFCE);

    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc);
    chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    issue(MDU_DIVU, 32'd100, 32'd0);
    wait_done(cyc);
    chk("divu_zero_latency", 64'(cyc), 64'd33);
    chk("divu_zero", {hi, lo}, {32'd100, 32'hFFFF_FFFF});
    chk("divu_zero_flag", 64'(div_by_zero), 64'd1);

    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd0);
    wait_done(cyc);
    chk("div_zero_signed", {hi, lo}, {32'hFFFF_FFF9, 32'hFFFF_FFFF});

    // Start while busy is ignored; start during done is accepted.
    issue(MDU_MULT, 32'd3, 32'd4);
    repeat (9) @(posedge CLK);
    #1 start = 1'b1; mduop = MDU_MULT; Port_A = 32'd9; Port_B = 32'd9;
    @(posedge CLK); #1 start = 1'b0;
    wait_done(cyc);
    chk("busy_start_ignored", {hi, lo}, 64'd12);
    start = 1'b1; mduop = MDU_MULTU; Port_A = 32'd7; Port_B = 32'd6;
    @(posedge CLK); #1 start = 1'b0;
    wait_done(cyc);
    chk("start_on_done", {hi, lo}, 64'd42);

    // Flush mid-run: no completion, results untouched.
    issue(MDU_DIVU, 32'd50, 32'd7);
    repeat (14) @(posedge CLK);
    #1 flush = 1'b1;
    @(posedge CLK); #1 flush = 1'b0;
    @(negedge CLK);
    chk("flush_busy", 64'(busy), 64'd0);
    ndone = 0;
    repeat (40) begin @(negedge CLK); if (done) ndone++; end
    chk("flush_no_done", 64'(ndone), 64'd0);
    chk("flush_hold", {hi, lo}, 64'd42);

    // Flush together with start in idle: nothing accepted.
    @(posedge CLK); #1 start = 1'b1; flush = 1'b1; mduop = MDU_MULTU; Port_A = 32'd5; Port_B = 32'd5;
    @(posedge CLK); #1 start = 1'b0; flush = 1'b0;
    @(negedge CLK);
    chk("flush_start_busy", 64'(busy), 64'd0);

    // Reset mid-run, then the overflow divide.
    issue(MDU_MULTU, 32'd123, 32'd456);
    repeat (8) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_mid_out", {hi, lo}, 64'd0);
    chk("rst_mid_ctl", {61'd0, busy, done, div_by_zero}, 64'd0);
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    chk("div_overflow", {hi, lo}, {32'd0, 32'h8000_0000});
    chk("div_overflow_flag", 64'(div_by_zero), 64'd0);

    // Free-running random traffic, checked entirely by the model.
    ndone = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK); #1;
      RST    = ($urandom_range(0, 299) == 0);
      start  = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 39) == 0);
      mduop  = mduop_t'($urandom_range(0, 3));
      Port_A = rand_word();
      Port_B = rand_word();
      if (done) ndone++;
    end
    RST = 1'b0; start = 1'b0; flush = 1'b0;
    repeat (40) @(posedge CLK);
    checks++;
    if (ndone < 10) begin
      errors++;
      $display("FAIL random_completions: got %0d expected at least 10", ndone);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
